// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - serial back end for the 16-character 5x7 dot-matrix hex display
module hex_display_driver #(
    parameter int         DIV_HALF  = 27,
    parameter logic [7:0] CTRL_WORD = 8'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] hex_data,
    input  logic        blank,
    output logic        disp_clock,
    output logic        disp_data_out,
    output logic        disp_rs,
    output logic        disp_ce_b,
    output logic        disp_reset_b,
    output logic        disp_blank,
    output logic        frame_done
);

    localparam logic [2:0] ST_RST_PULSE  = 3'd0;
    localparam logic [2:0] ST_CTRL_LOAD  = 3'd1;
    localparam logic [2:0] ST_CTRL_LATCH = 3'd2;
    localparam logic [2:0] ST_DATA_LOAD  = 3'd3;
    localparam logic [2:0] ST_DATA_LATCH = 3'd4;

    localparam int               DIV_W     = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_HALF - 1);
    localparam logic [9:0]       CTRL_LAST = 10'd7;
    localparam logic [9:0]       DATA_LAST = 10'd639;

    function automatic logic [39:0] glyph(input logic [3:0] nib);
        logic [39:0] g;
        case (nib)
            4'h0:    g = 40'h3E_51_49_45_3E;
            4'h1:    g = 40'h00_42_7F_40_00;
            4'h2:    g = 40'h42_61_51_49_46;
            4'h3:    g = 40'h21_41_45_4B_31;
            4'h4:    g = 40'h18_14_12_7F_10;
            4'h5:    g = 40'h27_45_45_45_39;
            4'h6:    g = 40'h3C_4A_49_49_30;
            4'h7:    g = 40'h01_71_09_05_03;
            4'h8:    g = 40'h36_49_49_49_36;
            4'h9:    g = 40'h06_49_49_29_1E;
            4'hA:    g = 40'h7E_11_11_11_7E;
            4'hB:    g = 40'h7F_49_49_49_36;
            4'hC:    g = 40'h3E_41_41_41_22;
            4'hD:    g = 40'h7F_41_41_22_1C;
            4'hE:    g = 40'h7F_49_49_49_41;
            default: g = 40'h7F_09_09_09_01;
        endcase
        return g;
    endfunction

    // Serial bit idx of a frame: char idx/40 (leftmost first), column byte, MSB first.
    function automatic logic dot_bit(input logic [63:0] frame, input logic [9:0] idx);
        logic [3:0]  ch;
        logic [5:0]  rem;
        logic [39:0] shifted;
        logic [7:0]  col_byte;
        ch       = 4'(idx / 10'd40);
        rem      = 6'(idx % 10'd40);
        shifted  = glyph(frame[{~ch, 2'b00} +: 4]) << {rem[5:3], 3'b000};
        col_byte = shifted[39:32];
        return col_byte[~rem[2:0]];
    endfunction

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       tick_cnt;
    logic [9:0]       bit_cnt;
    logic [9:0]       bit_nxt;
    logic [63:0]      frame;
    logic             first_done;
    logic             tick;

    assign tick    = (div_cnt == DIV_LAST);
    assign bit_nxt = bit_cnt + 10'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RST_PULSE;
            div_cnt       <= '0;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            frame         <= '0;
            first_done    <= 1'b0;
            disp_clock    <= 1'b0;
            disp_data_out <= 1'b0;
            disp_rs       <= 1'b0;
            disp_ce_b     <= 1'b1;
            disp_reset_b  <= 1'b0;
            disp_blank    <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            disp_blank <= first_done ? blank : 1'b1;
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                case (state)
                    ST_RST_PULSE: begin
                        if (tick_cnt == 3'd7) begin
                            state         <= ST_CTRL_LOAD;
                            disp_reset_b  <= 1'b1;
                            disp_rs       <= 1'b1;
                            disp_ce_b     <= 1'b0;
                            bit_cnt       <= '0;
                            disp_data_out <= CTRL_WORD[7];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_CTRL_LOAD: begin
                        if (!disp_clock) begin
                            disp_clock <= 1'b1;
                        end else begin
                            disp_clock <= 1'b0;
                            if (bit_cnt == CTRL_LAST) begin
                                state     <= ST_CTRL_LATCH;
                                disp_ce_b <= 1'b1;
                                tick_cnt  <= '0;
                                frame     <= hex_data;
                            end else begin
                                bit_cnt       <= bit_nxt;
                                disp_data_out <= CTRL_WORD[~bit_nxt[2:0]];
                            end
                        end
                    end
                    ST_DATA_LOAD: begin
                        if (!disp_clock) begin
                            disp_clock <= 1'b1;
                        end else begin
                            disp_clock <= 1'b0;
                            if (bit_cnt == DATA_LAST) begin
                                state      <= ST_DATA_LATCH;
                                disp_ce_b  <= 1'b1;
                                tick_cnt   <= '0;
                                frame      <= hex_data;
                                frame_done <= 1'b1;
                                first_done <= 1'b1;
                            end else begin
                                bit_cnt       <= bit_nxt;
                                disp_data_out <= dot_bit(frame, bit_nxt);
                            end
                        end
                    end
                    ST_CTRL_LATCH, ST_DATA_LATCH: begin
                        // Both latch states hold ce_b high for two ticks, then start a dot frame.
                        if (tick_cnt == 3'd1) begin
                            state         <= ST_DATA_LOAD;
                            disp_rs       <= 1'b0;
                            disp_ce_b     <= 1'b0;
                            bit_cnt       <= '0;
                            disp_data_out <= dot_bit(frame, 10'd0);
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_RST_PULSE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - directed self-checking bench for hex_display_driver
module tb_hex_display_driver;

    logic        clk;
    logic        reset;
    logic [63:0] hex_data;
    logic        blank;
    logic        disp_clock;
    logic        disp_data_out;
    logic        disp_rs;
    logic        disp_ce_b;
    logic        disp_reset_b;
    logic        disp_blank;
    logic        frame_done;

    hex_display_driver #(.DIV_HALF(2), .CTRL_WORD(8'h7F)) dut (
        .clk           (clk),
        .reset         (reset),
        .hex_data      (hex_data),
        .blank         (blank),
        .disp_clock    (disp_clock),
        .disp_data_out (disp_data_out),
        .disp_rs       (disp_rs),
        .disp_ce_b     (disp_ce_b),
        .disp_reset_b  (disp_reset_b),
        .disp_blank    (disp_blank),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int           cyc = 0;
    int           ctrl_cnt = 0;
    logic [7:0]   ctrl_shift = '0;
    int           dot_cnt = 0;
    logic [639:0] dot_shift = '0;
    logic [639:0] last_frame = '0;
    int           last_dot_cnt = 0;
    int           frames_seen = 0;
    int           fd_cyc [0:7];
    int           ce_viol = 0;
    int           latch_ctrl_cnt = 0;
    logic [7:0]   latch_ctrl_val = '0;
    int           latch_dot_cnt = 0;
    logic         prev_dclk = 1'b0;
    logic         prev_ce = 1'b1;

    // Serial receiver model: captures data on disp_clock rising edges.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            ctrl_cnt       = 0;
            ctrl_shift     = '0;
            dot_cnt        = 0;
            latch_ctrl_cnt = 0;
            latch_ctrl_val = '0;
            latch_dot_cnt  = 0;
        end else begin
            if (disp_clock && !prev_dclk) begin
                if (disp_ce_b) ce_viol++;
                if (disp_rs) begin
                    ctrl_shift = {ctrl_shift[6:0], disp_data_out};
                    ctrl_cnt++;
                end else begin
                    dot_shift = {dot_shift[638:0], disp_data_out};
                    dot_cnt++;
                end
            end
            if (disp_ce_b && !prev_ce && disp_rs) begin
                latch_ctrl_cnt = ctrl_cnt;
                latch_ctrl_val = ctrl_shift;
                latch_dot_cnt  = dot_cnt;
            end
            if (frame_done) begin
                last_frame   = dot_shift;
                last_dot_cnt = dot_cnt;
                dot_cnt      = 0;
                if (frames_seen < 8) fd_cyc[frames_seen] = cyc;
                frames_seen++;
            end
        end
        prev_dclk = disp_clock;
        prev_ce   = disp_ce_b;
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int target, input string tag);
        for (int i = 0; i < 6000 && frames_seen < target; i++) begin
            @(negedge clk); #1;
        end
        check_int(tag, int'(frames_seen >= target), 1);
    endtask

    task automatic wait_dots(input int target, input string tag);
        for (int i = 0; i < 6000 && dot_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        check_int(tag, int'(dot_cnt >= target), 1);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        blank    = 1'b0;
        hex_data = 64'h0123_4567_89AB_CDEF;

        repeat (5) @(negedge clk);
        #1;
        check_int("rst_clock", int'(disp_clock), 0);
        check_int("rst_data", int'(disp_data_out), 0);
        check_int("rst_rs", int'(disp_rs), 0);
        check_int("rst_ce_b", int'(disp_ce_b), 1);
        check_int("rst_reset_b", int'(disp_reset_b), 0);
        check_int("rst_blank", int'(disp_blank), 1);
        check_int("rst_frame_done", int'(frame_done), 0);

        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (disp_reset_b === 1'b1) begin
                n = i;
                break;
            end
        end
        check_int("reset_b_rise_clks", n, 16);

        wait_dots(10, "wait_frame1_start");
        check_int("blank_before_first_frame", int'(disp_blank), 1);
        check_int("ctrl_bit_count_at_latch", latch_ctrl_cnt, 8);
        check_int("ctrl_word", int'(latch_ctrl_val), 8'h7F);
        hex_data = 64'h0;

        wait_frames(1, "wait_frame1_done");
        check_int("frame1_bits", last_dot_cnt, 640);
        check_wide("frame1_char0", 640'(last_frame[639:600]), 640'(40'h3E_51_49_45_3E));
        check_wide("frame1_char1", 640'(last_frame[599:560]), 640'(40'h00_42_7F_40_00));
        check_wide("frame1_charF", 640'(last_frame[39:0]), 640'(40'h7F_09_09_09_01));

        @(negedge clk); #1;
        check_int("blank_follow_0", int'(disp_blank), 0);
        blank = 1'b1;
        #1;
        check_int("blank_latency_hold", int'(disp_blank), 0);
        @(posedge clk); #1;
        check_int("blank_follow_1", int'(disp_blank), 1);
        blank = 1'b0;
        @(posedge clk); #1;
        check_int("blank_follow_0_again", int'(disp_blank), 0);

        wait_dots(300, "wait_frame2_bit300");
        hex_data = 64'hAAAA_AAAA_AAAA_AAAA;
        wait_frames(2, "wait_frame2_done");
        check_wide("frame2_all_zero", last_frame, {16{40'h3E_51_49_45_3E}});
        wait_frames(3, "wait_frame3_done");
        check_wide("frame3_all_a", last_frame, {16{40'h7E_11_11_11_7E}});
        check_int("frame_done_spacing", fd_cyc[2] - fd_cyc[1], 2564);
        check_int("no_clock_edge_ce_high", ce_viol, 0);

        wait_dots(100, "wait_frame4_bit100");
        check_int("pre_reset_ce_b", int'(disp_ce_b), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_int("midrst_ce_b", int'(disp_ce_b), 1);
        check_int("midrst_reset_b", int'(disp_reset_b), 0);
        check_int("midrst_clock", int'(disp_clock), 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 400 && latch_ctrl_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        check_int("midrst_ctrl_bits", latch_ctrl_cnt, 8);
        check_int("midrst_ctrl_word", int'(latch_ctrl_val), 8'h7F);
        check_int("midrst_no_dots_before_ctrl", latch_dot_cnt, 0);
        wait_frames(4, "wait_frame_after_reset");
        check_int("post_reset_frame_bits", last_dot_cnt, 640);
        check_wide("post_reset_frame_a", last_frame, {16{40'h7E_11_11_11_7E}});
        check_int("no_clock_edge_ce_high_end", ce_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_driver.md
# hex_display_driver

- Serial back end for the 16-character dot-matrix hex display.
- Takes the 64-bit `my_hex_data` word produced by the display controller, i.e. 16 nibbles with nibble 15 the leftmost character.
- Renders each nibble through a 5x7 hex font and shifts the resulting 640-bit dot frame to the display chain over its serial interface.
- Generates the display's power-on reset and control-word load, then refreshes frames continuously.

## Interface

Parameters:
- `DIV_HALF`, default 27: clk cycles per half period of `disp_clock`. An internal `tick` fires every `DIV_HALF` cycles.
- `CTRL_WORD`, default 8'h7F: control word 0 value (max brightness, normal operation).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `hex_data` input 64: 16 hex digits; `[63:60]` is the leftmost character, `[3:0]` the rightmost.
- `blank` input 1: request display blanking.
- `disp_clock` output 1: serial shift clock to the display.
- `disp_data_out` output 1: serial data.
- `disp_rs` output 1: register select (1 = control register, 0 = dot register).
- `disp_ce_b` output 1: chip enable, active low. The rising edge latches the shifted word.
- `disp_reset_b` output 1: display reset, active low.
- `disp_blank` output 1: display blank, active high.
- `frame_done` output 1: one-clk pulse after each dot frame is latched.

## Operation

- Reset values (held while `reset`=1): `disp_clock`=0, `disp_data_out`=0, `disp_rs`=0, `disp_ce_b`=1, `disp_reset_b`=0, `disp_blank`=1, `frame_done`=0. State=RST_PULSE; tick divider, tick counter and bit counter are all 0.
- RST_PULSE:
  - `disp_reset_b`=0 for 8 ticks (4 disp_clock periods).
  - Then go to CTRL_LOAD with `disp_reset_b`=1, which it stays at until the next `reset`.
- CTRL_LOAD:
  - `disp_rs`=1, `disp_ce_b`=0.
  - Shift the 8 bits of `CTRL_WORD`, MSB first.
  - Go to CTRL_LATCH.
- CTRL_LATCH:
  - `disp_ce_b`=1 for 2 ticks.
  - Snapshot `hex_data` into an internal frame register.
  - Go to DATA_LOAD.
- DATA_LOAD:
  - `disp_rs`=0, `disp_ce_b`=0.
  - Shift 640 bits: characters 15 down to 0.
  - Each character is 5 column bytes, left column first. Each byte is MSB first, and bit 7 is always 0.
- DATA_LATCH:
  - `disp_ce_b`=1 for 2 ticks.
  - On entry, pulse `frame_done` for 1 clk and re-snapshot `hex_data`.
  - After the 2 ticks, return to DATA_LOAD.
- Snapshot rule: `hex_data` is sampled only at the snapshot points above. Input changes during a frame never tear the frame in progress.
- Font: the team's standard 5x7 hex glyph set. The glyphs used for checking are:
  - '0' = 3E 51 49 45 3E
  - '1' = 00 42 7F 40 00
  - 'A' = 7E 11 11 11 7E
  - 'F' = 7F 09 09 09 01
- Blanking: `disp_blank`=1 until the first `frame_done`. After that, `disp_blank` follows `blank`, registered, with 1 clk latency.
- Counters:
  - Bit counter is 10 bits, counting 0..639 in DATA_LOAD and 0..7 in CTRL_LOAD.
  - Character index = bit/40; column = (bit%40)/8; bit-in-byte = 7 - bit%8.

## Timing

- `tick` is a 1-clk strobe every `DIV_HALF` clk cycles. The first tick comes `DIV_HALF` cycles after `reset` deasserts.
- `disp_clock` toggles on every tick during CTRL_LOAD and DATA_LOAD only. It is held at 0 in RST_PULSE and in both LATCH states.
- Data bits:
  - Each serial bit occupies one disp_clock period, low half first.
  - `disp_data_out` changes only on the tick that drives `disp_clock` 1→0, or on state entry. It is therefore stable across every rising edge.
- `disp_rs` and `disp_ce_b` change only on state entry. State entry happens on a tick while `disp_clock`=0, so they are set up at least `DIV_HALF` cycles before the first rising edge.
- Period lengths:
  - Control sequence: 8 + 16 + 2 = 26 ticks.
  - Frame period: 1280 + 2 = 1282 ticks = 1282·`DIV_HALF` clk cycles.
  - `frame_done` pulses are spaced exactly 1282·`DIV_HALF` clks apart.
- `reset` asserted mid-frame: outputs take their reset values on the next clk edge. Frame and control state is discarded, and the sequence restarts at RST_PULSE.

## Test plan

- Reset check (`DIV_HALF`=2 in the bench):
  - Stimulus: hold `reset` for 5 clks.
  - Required: all outputs at their reset values. `disp_reset_b` rises exactly 16 clks after `reset` falls.
- Control load:
  - Required: during `disp_rs`=1, the 8 bits captured on `disp_clock` rising edges read 0x7F.
  - Required: `disp_ce_b` rises after the 8th edge, and `disp_clock` shows no edge while `disp_ce_b`=1.
- Frame content:
  - Stimulus: `hex_data`=64'h0123_4567_89AB_CDEF.
  - Required: the 640 captured bits begin with 3E 51 49 45 3E (char '0'), followed by 00 42 7F 40 00 ('1'), and end with 7F 09 09 09 01 ('F').
- Snapshot integrity:
  - Stimulus: change `hex_data` from all-0 to all-A (64'hAAAA_AAAA_AAAA_AAAA) at bit 300 of a frame.
  - Required: the current frame is all '0' glyphs, and the next frame is all 'A' glyphs (7E 11 11 11 7E). `frame_done` spacing is 2564 clks.
- Blank:
  - Required: `blank`=0 still leaves `disp_blank`=1 before the first `frame_done`.
  - After the first `frame_done`, toggling `blank` changes `disp_blank` 1 clk later.
- Mid-frame reset:
  - Stimulus: assert `reset` at bit 100 of DATA_LOAD.
  - Required: next clk has `disp_ce_b`=1, `disp_reset_b`=0, `disp_clock`=0. The full control sequence then repeats before any dot data is sent.
